// File: rtl/flash_playback_sequencer_pkg.sv
// audio_pkg: shared types and constants for the flash playback path.
//   seq_state_t        - playback sequencer FSM states
//   DIR_FW / DIR_BW    - playback direction encodings
//   ADDR_W_DEF         - default flash word-address width
//   MAX_ADDR_DEF       - default last word address of the clip
package audio_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    HALF0     = 3'd3,
    HALF1     = 3'd4
  } seq_state_t;

  localparam logic DIR_FW = 1'b0;
  localparam logic DIR_BW = 1'b1;

  localparam int          ADDR_W_DEF   = 23;
  localparam logic [22:0] MAX_ADDR_DEF = 23'h7FFFF;

endpackage

// File: rtl/flash_playback_sequencer_if.sv
// flash_if: Avalon-MM read-only port between the playback sequencer and the
// flash controller.
//   read, address              - request (master drives)
//   waitrequest                - request not yet accepted (slave drives)
//   readdata, readdatavalid    - returned word (slave drives)
interface flash_if #(parameter int ADDR_W = 23);
  logic              read;
  logic [ADDR_W-1:0] address;
  logic              waitrequest;
  logic [31:0]       readdata;
  logic              readdatavalid;

  modport master (output read, address, input waitrequest, readdata, readdatavalid);
  modport slave  (input read, address, output waitrequest, readdata, readdatavalid);
endinterface

// File: rtl/flash_playback_sequencer_play_addr_step.sv
// play_addr_step: combinational wrap-around address step.
//   addr      - current word address
//   dir       - DIR_FW steps up, DIR_BW steps down
//   next_addr - stepped address; MAX_ADDR wraps to 0 going forward,
//               0 wraps to MAX_ADDR going backward
module play_addr_step
  import audio_pkg::*;
#(
  parameter int              ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              dir,
  output logic [ADDR_W-1:0] next_addr
);
  // Explicit end-of-clip compares: the clip need not span the full address
  // range, so natural overflow would land outside it.
  always_comb begin
    next_addr = addr;
    if (dir == DIR_FW)
      next_addr = (addr == MAX_ADDR) ? '0 : addr + ADDR_W'(1);
    else
      next_addr = (addr == '0) ? MAX_ADDR : addr - ADDR_W'(1);
  end
endmodule

// File: rtl/flash_playback_sequencer.sv
// flash_playback_sequencer: fetches 32-bit words from flash and plays one
// 16-bit half per qualified sample tick, stepping the address with wrap.
//   clk, reset    - system clock, synchronous active-high reset
//   sample_tick   - audio-rate strobe
//   play          - 1 = playing, 0 = paused
//   dir           - 0 = forward, 1 = backward
//   restart       - pulse: jump to the clip start for the current dir
//   flash         - Avalon-MM read master port
//   sample        - current sample (registered)
//   sample_valid  - pulse when sample updates
//   underrun      - pulse when a qualified tick finds no buffered word
module flash_playback_sequencer
  import audio_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(MAX_ADDR_DEF)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        play,
  input  logic        dir,
  input  logic        restart,
  flash_if.master     flash,
  output logic [15:0] sample,
  output logic        sample_valid,
  output logic        underrun
);

  seq_state_t        state;
  logic              restart_pend;
  logic [31:0]       word;
  logic              word_dir;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] restart_addr;
  logic              qtick;
  logic              do_restart;

  play_addr_step #(.ADDR_W(ADDR_W), .MAX_ADDR(MAX_ADDR)) u_step (
    .addr      (flash.address),
    .dir       (dir),
    .next_addr (next_addr)
  );

  assign qtick        = sample_tick & play;
  assign do_restart   = restart | restart_pend;
  assign restart_addr = (dir == DIR_BW) ? MAX_ADDR : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      restart_pend  <= 1'b0;
      flash.read    <= 1'b0;
      flash.address <= '0;
      word          <= '0;
      word_dir      <= DIR_FW;
      sample        <= '0;
      sample_valid  <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      underrun     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (do_restart || play) begin
            if (do_restart) flash.address <= restart_addr;
            // a tick coinciding with restart has no data to play
            underrun     <= qtick & do_restart;
            restart_pend <= 1'b0;
            flash.read   <= 1'b1;
            state        <= REQ;
          end
        end
        REQ: begin
          if (restart) restart_pend <= 1'b1;
          if (qtick)   underrun     <= 1'b1;
          if (!flash.waitrequest) begin
            flash.read <= 1'b0;
            state      <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          if (qtick) underrun <= 1'b1;
          if (flash.readdatavalid) begin
            if (do_restart) begin
              // in-flight word belongs to the old position: drop it
              flash.address <= restart_addr;
              restart_pend  <= 1'b0;
              flash.read    <= 1'b1;
              state         <= REQ;
            end else begin
              word     <= flash.readdata;
              word_dir <= dir;
              state    <= HALF0;
            end
          end else if (restart) begin
            restart_pend <= 1'b1;
          end
        end
        HALF0, HALF1: begin
          if (do_restart) begin
            flash.address <= restart_addr;
            underrun      <= qtick;
            restart_pend  <= 1'b0;
            flash.read    <= 1'b1;
            state         <= REQ;
          end else if (qtick) begin
            sample_valid <= 1'b1;
            // word_dir fixes the half order for the whole word
            if ((state == HALF0) ^ (word_dir == DIR_BW))
              sample <= word[15:0];
            else
              sample <= word[31:16];
            if (state == HALF0) begin
              state <= HALF1;
            end else begin
              flash.address <= next_addr;
              flash.read    <= 1'b1;
              state         <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_flash_playback_sequencer.sv
module tb_flash_playback_sequencer;
  import audio_pkg::*;

  localparam logic [22:0] MAXA = 23'h7FFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_tick = 1'b0;
  logic        play = 1'b0;
  logic        dir = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] sample;
  logic        sample_valid;
  logic        underrun;

  int total = 0;
  int bad = 0;

  // responder knobs
  int wr_cycles = 0;
  int rd_lat = 1;
  logic [22:0] acc_addrs[$];

  flash_if #(.ADDR_W(23)) flash ();

  flash_playback_sequencer #(.ADDR_W(23), .MAX_ADDR(MAXA)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_tick  (sample_tick),
    .play         (play),
    .dir          (dir),
    .restart      (restart),
    .flash        (flash.master),
    .sample       (sample),
    .sample_valid (sample_valid),
    .underrun     (underrun)
  );

  always #10 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [22:0] a);
    if (a == 23'd0)          return 32'hBBBB_AAAA;
    else if (a == 23'd1)     return 32'hDDDD_CCCC;
    else if (a == MAXA)      return 32'h1111_2222;
    else if (a == MAXA - 23'd1) return 32'h3333_4444;
    else                     return {~a[15:0], a[15:0]};
  endfunction

  // Flash slave model: waitrequest held wr_cycles cycles per request,
  // readdatavalid rd_lat cycles after acceptance.
  initial begin
    logic        acc;
    logic [22:0] a;
    logic [22:0] paddr;
    int          cnt;
    int          wcnt;
    cnt = 0;
    wcnt = 0;
    paddr = '0;
    flash.waitrequest   = 1'b0;
    flash.readdata      = '0;
    flash.readdatavalid = 1'b0;
    forever begin
      @(posedge clk);
      acc = flash.read & ~flash.waitrequest;
      a   = flash.address;
      #1;
      flash.readdatavalid = 1'b0;
      if (acc) begin
        acc_addrs.push_back(a);
        paddr = a;
        cnt = rd_lat;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          flash.readdatavalid = 1'b1;
          flash.readdata      = word_at(paddr);
        end
      end
      if (flash.read && wcnt < wr_cycles) begin
        flash.waitrequest = 1'b1;
        wcnt++;
      end else begin
        flash.waitrequest = 1'b0;
        if (!flash.read) wcnt = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick();
    sample_tick = 1'b1;
    cyc(1);
    sample_tick = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    cyc(1);
    restart = 1'b0;
  endtask

  initial begin
    int hcnt;
    int stable;
    int vcnt;
    int rcnt;

    cyc(3);
    chk("rst_read", 32'(flash.read), 32'd0);
    chk("rst_addr", 32'(flash.address), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_valid", 32'(sample_valid), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    reset = 1'b0;

    // forward sequence
    play = 1'b1;
    dir  = 1'b0;
    cyc(6);
    chk("fw_addr0", 32'(acc_addrs[0]), 32'd0);
    tick();
    chk("fw_s0", 32'(sample), 32'h0000_AAAA);
    chk("fw_v0", 32'(sample_valid), 32'd1);
    tick();
    chk("fw_s1", 32'(sample), 32'h0000_BBBB);
    chk("fw_rd_after_tick", 32'(flash.read), 32'd1);
    cyc(6);
    tick();
    chk("fw_s2", 32'(sample), 32'h0000_CCCC);
    tick();
    chk("fw_s3", 32'(sample), 32'h0000_DDDD);
    chk("fw_nounderrun", 32'(underrun), 32'd0);
    cyc(6);
    chk("fw_naddr", 32'(acc_addrs.size()), 32'd3);
    chk("fw_addr1", 32'(acc_addrs[1]), 32'd1);
    chk("fw_addr2", 32'(acc_addrs[2]), 32'd2);

    // backward wrap via restart
    acc_addrs.delete();
    dir = 1'b1;
    pulse_restart();
    cyc(6);
    chk("bw_addr_max", 32'(acc_addrs[0]), 32'(MAXA));
    tick();
    chk("bw_s_hi", 32'(sample), 32'h0000_1111);
    tick();
    chk("bw_s_lo", 32'(sample), 32'h0000_2222);
    cyc(6);
    chk("bw_addr_dec", 32'(acc_addrs[$]), 32'(MAXA - 23'd1));

    // forward wrap at MAX_ADDR, dir changed mid-word
    acc_addrs.delete();
    pulse_restart();
    cyc(6);
    dir = 1'b0;
    tick();
    chk("fwr_s_hi", 32'(sample), 32'h0000_1111);
    tick();
    chk("fwr_s_lo", 32'(sample), 32'h0000_2222);
    cyc(6);
    chk("fwr_addr_wrap", 32'(acc_addrs[$]), 32'd0);

    // waitrequest hold: read/address stable through 5 stall cycles
    tick();
    chk("wr_s0", 32'(sample), 32'h0000_AAAA);
    wr_cycles = 5;
    acc_addrs.delete();
    tick();
    hcnt = 0;
    stable = 1;
    for (int i = 0; i < 20; i++) begin
      if (flash.read) begin
        hcnt++;
        if (flash.address !== 23'd1) stable = 0;
      end
      cyc(1);
    end
    wr_cycles = 0;
    chk("wr_read_cycles", 32'(hcnt), 32'd6);
    chk("wr_addr_stable", 32'(stable), 32'd1);
    chk("wr_acc_addr", 32'(acc_addrs[0]), 32'd1);

    // pause: tick ignored
    play = 1'b0;
    tick();
    chk("pause_valid", 32'(sample_valid), 32'd0);
    chk("pause_sample", 32'(sample), 32'h0000_BBBB);
    chk("pause_underrun", 32'(underrun), 32'd0);
    play = 1'b1;

    // underrun: tick while read data is late
    tick();
    chk("ur_s0", 32'(sample), 32'h0000_CCCC);
    rd_lat = 4;
    tick();
    chk("ur_s1", 32'(sample), 32'h0000_DDDD);
    cyc(2);
    tick();
    chk("ur_pulse", 32'(underrun), 32'd1);
    chk("ur_novalid", 32'(sample_valid), 32'd0);
    chk("ur_hold", 32'(sample), 32'h0000_DDDD);
    cyc(1);
    chk("ur_once", 32'(underrun), 32'd0);
    cyc(6);
    rd_lat = 1;
    tick();
    chk("ur_late_word", 32'(sample), 32'h0000_0002);

    // restart in flight: returned word dropped, refetch at 0
    rd_lat = 4;
    acc_addrs.delete();
    tick();
    chk("rf_s", 32'(sample), 32'h0000_FFFD);
    pulse_restart();
    vcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (sample_valid) vcnt++;
      cyc(1);
    end
    chk("rf_novalid", 32'(vcnt), 32'd0);
    chk("rf_sample_hold", 32'(sample), 32'h0000_FFFD);
    chk("rf_nacc", 32'(acc_addrs.size()), 32'd2);
    chk("rf_addr3", 32'(acc_addrs[0]), 32'd3);
    chk("rf_addr0", 32'(acc_addrs[$]), 32'd0);
    rd_lat = 1;
    tick();
    chk("rf_s_after", 32'(sample), 32'h0000_AAAA);

    // reset in WAIT_DATA with a stray readdatavalid afterwards
    rd_lat = 4;
    tick();
    chk("rs_s", 32'(sample), 32'h0000_BBBB);
    cyc(2);
    reset = 1'b1;
    play  = 1'b0;
    cyc(1);
    reset = 1'b0;
    vcnt = 0;
    rcnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (sample_valid) vcnt++;
      if (flash.read) rcnt++;
      cyc(1);
    end
    chk("rs_novalid", 32'(vcnt), 32'd0);
    chk("rs_noread", 32'(rcnt), 32'd0);
    chk("rs_addr", 32'(flash.address), 32'd0);
    chk("rs_sample", 32'(sample), 32'd0);
    chk("rs_underrun", 32'(underrun), 32'd0);
    chk("rs_state", 32'(dut.state), 32'(IDLE));
    rd_lat = 1;
    play = 1'b1;
    cyc(6);
    tick();
    chk("rs_replay", 32'(sample), 32'h0000_AAAA);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
